// File: rtl/gf2m_ds_mul_pkg.sv
// ec_gf2m_pkg: shared types and helpers for the GF(2^M) multiplier slice.
//   op_e      : operation select captured at start (multiply / k-fold square)
//   state_e   : controller states
//   ceil_div  : integer ceiling division for digit counts
//   gf2m_red  : fold a (2m-1)-bit polynomial down to m bits modulo x^m + poly
package ec_gf2m_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_SQR = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SQR,
        FIN
    } state_e;

    // Largest SEC 2 binary field; sizes the generic reduction helper.
    localparam int unsigned MAX_M = 571;
    localparam int unsigned RED_W = 2 * MAX_M - 1;
    localparam int unsigned IDX_W = $clog2(RED_W);

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    // Clears bits 2m-2 down to m, top first. Each cleared bit adds poly shifted
    // below it, which only lands on lower bits because deg(poly) < m.
    function automatic logic [MAX_M-1:0] gf2m_red(input logic [RED_W-1:0] v,
                                                  input int unsigned     m,
                                                  input logic [MAX_M-1:0] poly);
        logic [RED_W-1:0] t;
        logic [RED_W-1:0] p;
        logic [IDX_W-1:0] idx;
        t = v;
        p = RED_W'(poly);
        for (int unsigned i = 0; i < MAX_M - 1; i++) begin
            if (i + 1 < m) begin
                idx = IDX_W'(2 * m - 2 - i);
                if (t[idx]) begin
                    t[idx] = 1'b0;
                    t      = t ^ (p << (int'(idx) - int'(m)));
                end
            end
        end
        return t[MAX_M-1:0];
    endfunction

endpackage

// File: rtl/gf2m_ds_mul_digit_step.sv
// gf2m_digit_step: combinational digit step of the MSB-first multiplier.
//   acc_next = (acc * x^DIGIT + a * digit) mod (x^M + POLY)
// Ports:
//   acc      in  M      running accumulator
//   a        in  M      multiplicand
//   digit    in  DIGIT  current digit of b, MSB first
//   acc_next out M      updated, fully reduced accumulator
module gf2m_digit_step #(
    parameter int unsigned      M     = 163,
    parameter logic [M-1:0]     POLY  = 'hC9,
    parameter int unsigned      DIGIT = 4
) (
    input  logic [M-1:0]     acc,
    input  logic [M-1:0]     a,
    input  logic [DIGIT-1:0] digit,
    output logic [M-1:0]     acc_next
);

    // Horner over the digit bits: multiply by x with an immediate one-bit
    // reduction, then add a where the digit bit is set. Stays reduced each step.
    always_comb begin
        acc_next = acc;
        for (int unsigned j = 0; j < DIGIT; j++) begin
            acc_next = {acc_next[M-2:0], 1'b0} ^ (acc_next[M-1] ? POLY : '0);
            if (digit[DIGIT-1-j]) begin
                acc_next = acc_next ^ a;
            end
        end
    end

endmodule

// File: rtl/gf2m_ds_mul.sv
// gf2m_ds_mul: digit-serial GF(2^M) multiplier / k-fold squarer, polynomial basis.
//   One op in flight; start is sampled only while idle.
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous reset, active-high
//   clr      in   1   synchronous abort/clear (same effect as rst)
//   start    in   1   launch op when busy=0
//   op       in   1   0=MUL, 1=SQR (captured at start)
//   sqr_cnt  in   CW  number of squarings for SQR (captured at start)
//   a        in   M   operand a (captured at start)
//   b        in   M   operand b, MUL only (captured at start)
//   busy     out  1   op in flight
//   done     out  1   one-cycle pulse, z valid
//   z        out  M   result, held until next completion, clr or rst
module gf2m_ds_mul
    import ec_gf2m_pkg::*;
#(
    parameter int unsigned  M     = 163,
    parameter logic [M-1:0] POLY  = 'hC9,
    parameter int unsigned  DIGIT = 4,
    parameter int unsigned  CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          start,
    input  logic          op,
    input  logic [CW-1:0] sqr_cnt,
    input  logic [M-1:0]  a,
    input  logic [M-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [M-1:0]  z
);

    localparam int unsigned N    = ceil_div(M, DIGIT);
    localparam int unsigned NB   = N * DIGIT;
    localparam int unsigned CMAX = (N > (2 ** CW)) ? N : (2 ** CW);
    localparam int unsigned CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

    state_e            state;
    state_e            state_nx;
    logic [M-1:0]      a_r;
    logic [NB-1:0]     b_r;
    logic [M-1:0]      acc;
    logic [CNTW-1:0]   cnt;
    logic [M-1:0]      step_next;
    logic [M-1:0]      sq_next;
    logic [RED_W-1:0]  sq_wide;

    gf2m_digit_step #(
        .M     (M),
        .POLY  (POLY),
        .DIGIT (DIGIT)
    ) u_step (
        .acc      (acc),
        .a        (a_r),
        .digit    (b_r[NB-1 -: DIGIT]),
        .acc_next (step_next)
    );

    // Squaring in GF(2) is a bit spread (coefficient i moves to 2i), then fold.
    always_comb begin
        sq_wide = '0;
        for (int unsigned i = 0; i < M; i++) begin
            sq_wide[2*i] = acc[i];
        end
        sq_next = M'(gf2m_red(sq_wide, M, MAX_M'(POLY)));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // cnt holds remaining steps minus one, so the last MUL/SQR edge sees cnt==0.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_nx = MUL;
                    end else if (sqr_cnt != '0) begin
                        state_nx = SQR;
                    end else begin
                        state_nx = FIN;
                    end
                end
            end
            MUL, SQR: begin
                if (cnt == '0) begin
                    state_nx = FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            z    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= NB'(b);
                        if (op == OP_MUL) begin
                            acc <= '0;
                            cnt <= CNTW'(N - 1);
                        end else begin
                            acc <= a;
                            cnt <= CNTW'(sqr_cnt) - CNTW'(1);
                        end
                    end
                end
                MUL: begin
                    acc <= step_next;
                    b_r <= b_r << DIGIT;
                    cnt <= cnt - CNTW'(1);
                end
                SQR: begin
                    acc <= sq_next;
                    cnt <= cnt - CNTW'(1);
                end
                FIN: begin
                    z    <= acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
